// File: rtl/multiclock_issue.sv
// Issue/writeback controller in front of a fixed-latency multi-cycle M-extension ALU.
// Optional feature: define MULTICLOCK_DIV0_BYPASS_EN to resolve DIV/REM-by-zero without using the ALU.
module multiclock_issue #(
   parameter int LATENCY = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   input  logic [5:0]  req_alucode,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   input  logic [4:0]  req_rd,
   output logic        stall,
   output logic        alu_start,
   output logic [5:0]  alu_alucode,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   input  logic [31:0] alu_result,
   input  logic        alu_done,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        err
);

   localparam int CW = ($clog2(LATENCY) > 3) ? $clog2(LATENCY) : 3;
   localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          accept;
   logic          wb_load;
   logic [31:0]   wb_load_data;
   logic          err_set;
   logic          bypass;
   logic [31:0]   bypass_data;

`ifdef MULTICLOCK_DIV0_BYPASS_EN
   localparam logic [5:0] ALU_DIV  = 6'd36;
   localparam logic [5:0] ALU_DIVU = 6'd37;
   localparam logic [5:0] ALU_REM  = 6'd38;
   localparam logic [5:0] ALU_REMU = 6'd39;

   // Division by zero has an architecturally fixed result, so the ALU is skipped.
   always_comb begin
      bypass      = 1'b0;
      bypass_data = '0;
      if (req_op2 == 32'd0) begin
         if (req_alucode == ALU_DIV || req_alucode == ALU_DIVU) begin
            bypass      = 1'b1;
            bypass_data = 32'hffff_ffff;
         end else if (req_alucode == ALU_REM || req_alucode == ALU_REMU) begin
            bypass      = 1'b1;
            bypass_data = req_op1;
         end
      end
   end
`else
   assign bypass      = 1'b0;
   assign bypass_data = '0;
`endif

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      accept       = 1'b0;
      wb_load      = 1'b0;
      wb_load_data = '0;
      err_set      = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && !flush) begin
               accept   = 1'b1;
               cnt_next = '0;
               if (bypass) begin
                  wb_load      = 1'b1;
                  wb_load_data = bypass_data;
                  state_next   = WB;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (flush) begin
               cnt_next   = '0;
               state_next = DRAIN;
            end else begin
               cnt_next   = cnt + 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               cnt_next   = '0;
               state_next = DRAIN;
            end else begin
               cnt_next = cnt + 1'b1;
               if (alu_done && cnt == LAST) begin
                  wb_load      = 1'b1;
                  wb_load_data = alu_result;
                  state_next   = WB;
               end else if (alu_done || cnt == LAST) begin
                  // Early or missing done means the ALU latency assumption is broken.
                  err_set      = 1'b1;
                  wb_load      = 1'b1;
                  wb_load_data = '0;
                  state_next   = WB;
               end
            end
         end
         WB: begin
            state_next = IDLE;
         end
         DRAIN: begin
            if (cnt == LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = DRAIN;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DRAIN;
         cnt       <= '0;
         alu_start <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         alu_start <= (state_next == ISSUE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_alucode <= '0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         wb_rd       <= '0;
         wb_data     <= '0;
         err         <= 1'b0;
      end else begin
         if (accept) begin
            alu_alucode <= req_alucode;
            alu_op1     <= req_op1;
            alu_op2     <= req_op2;
            wb_rd       <= req_rd;
         end
         if (wb_load) begin
            wb_data <= wb_load_data;
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   assign stall    = ((state == IDLE) && req_valid) || (state == ISSUE) || (state == WAIT) ||
                     ((state == DRAIN) && req_valid);
   assign wb_valid = (state == WB) && !flush;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_multiclock_issue.sv
// Directed bench for multiclock_issue: behavioural fixed-latency ALU plus a writeback scoreboard.
module tb_multiclock_issue;

   localparam int LAT = 6;
   localparam logic [5:0] ALU_MUL   = 6'd32;
   localparam logic [5:0] ALU_MULHU = 6'd35;
   localparam logic [5:0] ALU_DIV   = 6'd36;
   localparam logic [5:0] ALU_DIVU  = 6'd37;
   localparam logic [5:0] ALU_REM   = 6'd38;
   localparam logic [5:0] ALU_REMU  = 6'd39;
`ifdef MULTICLOCK_DIV0_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic [5:0]  req_alucode;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic [4:0]  req_rd;
   logic        stall;
   logic        alu_start;
   logic [5:0]  alu_alucode;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [31:0] alu_result;
   logic        alu_done;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy;
   logic        err;

   multiclock_issue #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
      .req_alucode(req_alucode), .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd),
      .stall(stall), .alu_start(alu_start), .alu_alucode(alu_alucode),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result), .alu_done(alu_done),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU model: done pulses LAT-1 cycles after the cycle alu_start is high; result decoded from live code.
   logic [LAT-2:0] pipe = '0;
   logic           suppress_done = 1'b0;
   logic           force_done = 1'b0;
   always @(posedge clk) pipe <= {pipe[LAT-3:0], alu_start};
   assign alu_done = (pipe[LAT-2] & ~suppress_done) | force_done;

   function automatic logic [31:0] alu_model(input logic [5:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (code)
         ALU_MUL:   return p[31:0];
         ALU_MULHU: return p[63:32];
         ALU_DIV:   return (b == 0) ? 32'hffff_ffff : 32'($signed(a) / $signed(b));
         ALU_DIVU:  return (b == 0) ? 32'hffff_ffff : a / b;
         ALU_REM:   return (b == 0) ? a : 32'($signed(a) % $signed(b));
         ALU_REMU:  return (b == 0) ? a : a % b;
         default:   return 32'd0;
      endcase
   endfunction
   assign alu_result = alu_model(alu_alucode, alu_op1, alu_op2);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          when;
   } wb_exp_t;
   wb_exp_t sb[$];
   wb_exp_t e;

   always @(negedge clk) begin
      if (wb_valid !== 1'b0) begin
         if (sb.size() == 0) begin
            check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
            check("wb_data", wb_data, e.data);
            check("wb_cycle", cyc, e.when);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request, holds it until stall drops, checks stall/alu_start every cycle.
   task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int wait_cyc,
                         input bit byp);
      int lat;
      lat = wait_cyc + (byp ? 1 : LAT + 1);
      req_valid = 1'b1; req_alucode = code; req_op1 = a; req_op2 = b; req_rd = rd;
      sb.push_back('{rd: rd, data: exp, when: cyc + lat});
      for (int k = 0; k <= lat; k++) begin
         #1;
         check("stall", {31'b0, stall}, {31'b0, (k < lat)});
         check("alu_start", {31'b0, alu_start}, {31'b0, (!byp && k == wait_cyc + 1)});
         step();
      end
      req_valid = 1'b0;
   endtask

   // One-cycle reset, then verify reset values and the LAT-cycle drain.
   task automatic reset_and_drain();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_alu_start", {31'b0, alu_start}, 32'd0);
      check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      for (int k = 0; k < LAT; k++) begin
         check("drain_busy", {31'b0, busy}, 32'd1);
         step();
      end
      check("idle_busy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
      req_alucode = '0; req_op1 = '0; req_op2 = '0; req_rd = '0;
      step();
      step();
      check("reset_busy", {31'b0, busy}, 32'd1);
      check("reset_wb_data", wb_data, 32'd0);
      check("reset_wb_rd", {27'b0, wb_rd}, 32'd0);
      check("reset_alu_code", {26'b0, alu_alucode}, 32'd0);
      check("reset_alu_op1", alu_op1, 32'd0);
      check("reset_alu_op2", alu_op2, 32'd0);
      check("reset_stall", {31'b0, stall}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         check("post_reset_busy", {31'b0, busy}, 32'd1);
         step();
      end
      check("post_reset_idle", {31'b0, busy}, 32'd0);

      run_op(ALU_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 0, 1'b0);
      check("mul_alu_code", {26'b0, alu_alucode}, {26'b0, ALU_MUL});

      run_op(ALU_MULHU, 32'hffff_ffff, 32'hffff_ffff, 5'd6, 32'hffff_fffe, 0, 1'b0);
      run_op(ALU_DIV, 32'hffff_fff9, 32'd2, 5'd7, 32'hffff_fffd, 0, 1'b0);
      check("b2b_err", {31'b0, err}, 32'd0);

      run_op(ALU_DIVU, 32'd100, 32'd0, 5'd8, 32'hffff_ffff, 0, BYP);
      run_op(ALU_REMU, 32'd55, 32'd0, 5'd9, 32'd55, 0, BYP);

      // Flush in WAIT (c+3): no writeback, the stale done lands in DRAIN.
      req_valid = 1'b1; req_alucode = ALU_MUL; req_op1 = 32'd5; req_op2 = 32'd5; req_rd = 5'd20;
      step(); step(); step();
      flush = 1'b1; req_valid = 1'b0;
      step();
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd1);
      run_op(ALU_MUL, 32'd3, 32'd3, 5'd10, 32'd9, LAT, 1'b0);
      check("flush_err", {31'b0, err}, 32'd0);

      // Missing done: timeout at cnt==LATENCY-1 writes zero and sets err.
      suppress_done = 1'b1;
      run_op(ALU_MUL, 32'd3, 32'd4, 5'd14, 32'd0, 0, 1'b0);
      suppress_done = 1'b0;
      check("timeout_err", {31'b0, err}, 32'd1);
      reset_and_drain();

      // Early done at cnt=2 (cycle c+3): err set, wb_data=0 in c+4.
      req_valid = 1'b1; req_alucode = ALU_MUL; req_op1 = 32'd2; req_op2 = 32'd2; req_rd = 5'd11;
      sb.push_back('{rd: 5'd11, data: 32'd0, when: cyc + 4});
      step(); step(); step();
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      check("early_err", {31'b0, err}, 32'd1);
      step();
      req_valid = 1'b0;
      step(); step(); step();
      check("err_sticky", {31'b0, err}, 32'd1);
      check("early_idle", {31'b0, busy}, 32'd0);
      reset_and_drain();

      // Reset in c+4: the pending writeback is lost, then a fresh request completes.
      req_valid = 1'b1; req_alucode = ALU_MUL; req_op1 = 32'd4; req_op2 = 32'd4; req_rd = 5'd12;
      step(); step(); step(); step();
      req_valid = 1'b0;
      reset_and_drain();
      run_op(ALU_MUL, 32'd9, 32'd9, 5'd13, 32'd81, 0, 1'b0);
      check("final_err", {31'b0, err}, 32'd0);

      for (int k = 0; k < 4; k++) step();
      check("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
